// File: rtl/dsp_issue_ctrl.sv
// Command-side issue controller for a DSP48A1 slice: registers operands onto the
// slice, tracks its fixed latency and returns P/CARRYOUT in issue order.
module dsp_issue_ctrl #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [TAGW-1:0] cmd_tag,
  input  logic [17:0]     cmd_a,
  input  logic [17:0]     cmd_b,
  input  logic [17:0]     cmd_d,
  input  logic [47:0]     cmd_c,
  output logic [17:0]     dsp_a,
  output logic [17:0]     dsp_b,
  output logic [17:0]     dsp_d,
  output logic [47:0]     dsp_c,
  output logic [7:0]      dsp_opmode,
  input  logic [47:0]     dsp_p,
  input  logic            dsp_carryout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [47:0]     res_p,
  output logic            res_carry,
  output logic [TAGW-1:0] res_tag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake rule on both sides: a transfer happens on the rising edge where
  // valid and ready are both high; valid never depends on ready.
  logic            run;
  logic            accept;
  logic            pop;
  logic            capture;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   fifo_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      op_mode;

  logic [LATENCY-1:0] vld_pipe;
  logic [TAGW-1:0]    tag_pipe [LATENCY];

  logic [47:0]     p_mem [DEPTH];
  logic            c_mem [DEPTH];
  logic [TAGW-1:0] t_mem [DEPTH];

  // Credits cover both in-flight and buffered results, so a capture always has room.
  assign cmd_ready = run && (out_cnt < CW'(DEPTH));
  assign accept    = cmd_valid && cmd_ready;
  assign pop       = res_valid && res_ready;
  assign capture   = vld_pipe[LATENCY-1];

  always_comb begin
    op_mode = 8'h00;
    case (cmd_op)
      2'b00:   op_mode = 8'b0011_0101;
      2'b01:   op_mode = 8'b0001_1101;
      2'b10:   op_mode = 8'b0101_0101;
      default: op_mode = 8'b0000_0000;
    endcase
  end

  // Holds cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_a      <= '0;
      dsp_b      <= '0;
      dsp_d      <= '0;
      dsp_c      <= '0;
      dsp_opmode <= 8'h00;
    end else if (accept) begin
      dsp_a      <= cmd_a;
      dsp_b      <= cmd_b;
      dsp_d      <= cmd_d;
      dsp_c      <= cmd_c;
      dsp_opmode <= op_mode;
    end
  end

  // Stage LATENCY-1 marks the edge on which dsp_p holds this command's result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= accept;
      tag_pipe[0] <= cmd_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        p_mem[i] <= '0;
        c_mem[i] <= 1'b0;
        t_mem[i] <= '0;
      end
    end else begin
      if (capture) begin
        p_mem[wr_ptr] <= dsp_p;
        c_mem[wr_ptr] <= dsp_carryout;
        t_mem[wr_ptr] <= tag_pipe[LATENCY-1];
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({capture, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign res_valid = (fifo_cnt != '0);
  assign res_p     = p_mem[rd_ptr];
  assign res_carry = c_mem[rd_ptr];
  assign res_tag   = t_mem[rd_ptr];

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Bench for dsp_issue_ctrl: behavioural DSP48A1 model on the slice side and an
// expected-result queue filled at accept time, drained as results are popped.
module tb_dsp_issue_ctrl;

  localparam int LAT   = 4;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam int RW    = 49 + TAGW;
  localparam int NS    = LAT - 1;
  localparam logic [47:0] PCIN = 48'd5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [TAGW-1:0] cmd_tag;
  logic [17:0]     cmd_a, cmd_b, cmd_d;
  logic [47:0]     cmd_c;
  logic [17:0]     dsp_a, dsp_b, dsp_d;
  logic [47:0]     dsp_c;
  logic [7:0]      dsp_opmode;
  logic [47:0]     dsp_p;
  logic            dsp_carryout;
  logic            res_valid;
  logic            res_ready;
  logic [47:0]     res_p;
  logic            res_carry;
  logic [TAGW-1:0] res_tag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [RW-1:0] exp_q[$];
  int pop_cyc[$];
  logic [TAGW-1:0] next_tag = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_issue_ctrl #(.LATENCY(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_d(cmd_d), .cmd_c(cmd_c),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
    .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_p(res_p), .res_carry(res_carry), .res_tag(res_tag)
  );

  // DSP48A1 model decoded from OPMODE bits; P settles LAT edges after the ports change.
  logic [17:0] m_pre;
  logic [35:0] m_mul;
  logic [47:0] m_x, m_z;
  logic [48:0] m_sum;
  logic [48:0] stg [NS];

  always_comb begin
    m_pre = dsp_opmode[4] ? (dsp_opmode[6] ? dsp_d - dsp_b : dsp_d + dsp_b) : dsp_b;
    m_mul = 36'(m_pre) * 36'(dsp_a);
    case (dsp_opmode[1:0])
      2'b00:   m_x = '0;
      2'b01:   m_x = 48'(m_mul);
      2'b10:   m_x = dsp_p;
      default: m_x = {dsp_d[11:0], dsp_a, dsp_b};
    endcase
    case (dsp_opmode[3:2])
      2'b00:   m_z = '0;
      2'b01:   m_z = PCIN;
      2'b10:   m_z = dsp_p;
      default: m_z = dsp_c;
    endcase
    m_sum = 49'(m_z) + 49'(m_x) + 49'(dsp_opmode[5]);
  end

  always @(posedge clk) begin
    stg[0] <= m_sum;
    for (int i = 1; i < NS; i++) stg[i] <= stg[i-1];
  end

  assign dsp_p        = stg[NS-1][47:0];
  assign dsp_carryout = stg[NS-1][48];

  function automatic logic [48:0] model_res(input logic [1:0] op, input logic [17:0] a,
                                            input logic [17:0] b, input logic [47:0] c,
                                            input logic [17:0] d);
    logic [17:0] pre;
    logic [35:0] m;
    logic [48:0] r;
    pre = (op == 2'b10) ? d - b : d + b;
    m   = 36'(pre) * 36'(a);
    case (op)
      2'b00:   r = 49'(m) + 49'(PCIN) + 49'd1;
      2'b01:   r = 49'(c) + 49'(m);
      2'b10:   r = 49'(m) + 49'(PCIN);
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_result", 64'(res_valid), 64'd0);
      end else begin
        check("result", 64'({res_carry, res_p, res_tag}), 64'(exp_q.pop_front()));
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic rand_cmd();
    cmd_op  = 2'($urandom_range(0, 3));
    cmd_a   = 18'($urandom_range(0, 4000));
    cmd_b   = 18'($urandom_range(0, 4000));
    cmd_d   = cmd_b + 18'($urandom_range(0, 4000));
    cmd_c   = {16'($urandom), 32'($urandom)};
    cmd_tag = next_tag;
    next_tag = next_tag + 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [TAGW-1:0] tag, input logic [17:0] a,
                      input logic [17:0] b, input logic [47:0] c, input logic [17:0] d,
                      output int acc_cyc);
    logic done;
    done = 1'b0;
    acc_cyc = -1;
    cmd_op = op; cmd_tag = tag; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        exp_q.push_back({model_res(op, a, b, c, d), tag});
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic hold_valid(input int n, input bit rnd, output int acc);
    logic fire;
    acc = 0;
    rand_cmd();
    cmd_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fire = cmd_valid && cmd_ready;
      if (fire) begin
        exp_q.push_back({model_res(cmd_op, cmd_a, cmd_b, cmd_c, cmd_d), cmd_tag});
        acc++;
      end
      @(posedge clk);
      #1;
      if (fire || !cmd_valid) rand_cmd();
      if (rnd) begin
        if (fire || !cmd_valid) cmd_valid = ($urandom_range(0, 3) != 0);
        res_ready = ($urandom_range(0, 2) != 0);
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int k1, k2, acc;
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = '0; cmd_tag = '0; cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_d = '0;
    #2;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_outputs", 64'({res_valid, res_carry, res_tag, dsp_opmode}), 64'd0);
    check("rst_res_p", 64'(res_p), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_release", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle", 64'({res_valid, dsp_opmode}), 64'd0);
    end

    // Op 00 single command: latency and OPMODE.
    @(posedge clk); #1;
    send(2'b00, 4'h9, 18'd120, 18'd110, 48'd0, 18'd48, k1);
    @(negedge clk);
    check("opmode_op00", 64'(dsp_opmode), 64'h35);
    check("res_valid_k", 64'(res_valid), 64'd0);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      check("res_valid_early", 64'(res_valid), 64'd0);
    end
    @(negedge clk);
    check("res_valid_on_time", 64'(res_valid), 64'd1);
    check("op00_p", 64'(res_p), 64'd18966);
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_drain("drain_op00");

    // Back-to-back op 01 then op 10.
    pop_cyc.delete();
    send(2'b01, 4'h1, 18'd3, 18'd4, 48'd10, 18'd5, k1);
    send(2'b10, 4'h2, 18'd2, 18'd3, 48'd0, 18'd55, k2);
    check("b2b_accept_gap", 64'(k2 - k1), 64'd1);
    wait_drain("drain_b2b");
    check("b2b_pops", 64'(pop_cyc.size()), 64'd2);
    if (pop_cyc.size() == 2) check("b2b_pop_gap", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);

    // Flush between two op 01 commands.
    send(2'b01, 4'h5, 18'd3, 18'd4, 48'd10, 18'd5, k1);
    send(2'b11, 4'h6, 18'd77, 18'd66, 48'd999, 18'd88, k1);
    send(2'b01, 4'h7, 18'd100, 18'd20, 48'hFFFF_FFFF_FFF0, 18'd30, k1);
    wait_drain("drain_flush");

    // Backpressure: credits limit accepts to DEPTH.
    @(posedge clk); #1;
    res_ready = 1'b0;
    hold_valid(10, 1'b0, acc);
    check("bp_accepts", 64'(acc), 64'(DEPTH));
    @(negedge clk);
    check("bp_ready_low", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    hold_valid(8, 1'b0, acc);
    check("bp_one_more", 64'(acc), 64'd1);
    res_ready = 1'b1;
    wait_drain("drain_bp");

    // Reset mid-flight discards everything.
    res_ready = 1'b0;
    send(2'b00, 4'hA, 18'd1, 18'd2, 48'd0, 18'd3, k1);
    send(2'b01, 4'hB, 18'd4, 18'd5, 48'd6, 18'd7, k1);
    send(2'b10, 4'hC, 18'd8, 18'd9, 48'd0, 18'd10, k1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("mid_rst_outputs", 64'({res_valid, res_carry, res_tag, dsp_opmode}), 64'd0);
    check("mid_rst_dsp", 64'(dsp_c) | 64'(dsp_a) | 64'(dsp_b) | 64'(dsp_d) | 64'(res_p), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(res_valid), 64'd0);
    end
    check("post_rst_ready", 64'(cmd_ready), 64'd1);

    // Random traffic with random backpressure.
    @(posedge clk); #1;
    hold_valid(400, 1'b1, acc);
    res_ready = 1'b1;
    wait_drain("drain_random");
    @(negedge clk);
    check("final_ready", 64'(cmd_ready), 64'd1);
    check("final_empty", 64'(res_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
